// File: rtl/result_buffer.sv
// result_buffer: captures an n x n matrix of 32-bit results written in any
// order at (row, col). Once every entry is present it replays the matrix in
// row-major order over a value_stb / value_ack handshake.
module result_buffer #(
  parameter int unsigned n = 8  // matrix dimension, 1..31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [4:0]  wr_row,
  input  logic [4:0]  wr_col,
  input  logic [31:0] wr_data,
  output logic        full,
  input  logic        start,
  output logic [31:0] value,
  output logic        value_stb,
  input  logic        value_ack,
  output logic [4:0]  i,
  output logic [4:0]  j,
  output logic        done
);

  localparam int unsigned DEPTH = n * n;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [4:0]    LAST     = 5'(n - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_FILL,
    S_READY,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [DEPTH-1:0]  valid_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              full_q;
  logic              stb_q;
  logic              done_q;
  logic [4:0]        i_q;
  logic [4:0]        j_q;
  logic [31:0]       value_q;

  logic [31:0]       mem [DEPTH];

  logic              wr_in_range;
  logic              wr_accept;
  logic              wr_new;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     rd_addr;

  // Write qualification and row-major address generation.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    wr_in_range = (wr_row <= LAST) && (wr_col <= LAST);
    wr_accept   = (state_q == S_FILL) && wr_en && wr_in_range;
    wr_addr     = AW'(wr_row) * AW'(n) + AW'(wr_col);
    rd_addr     = AW'(i_q) * AW'(n) + AW'(j_q);
    wr_new      = wr_accept && !valid_q[wr_addr];
    cnt_d       = cnt_q + CW'(wr_new);
  end

  // Result storage: written only by accepted in-range writes during fill.
  // NOTE: the array has no reset; the valid bitmap alone decides which entries exist.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Control FSM with registered handshake/status outputs and the read register.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state_q <= S_FILL;
      valid_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      value_q <= '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (wr_accept) begin
            valid_q[wr_addr] <= 1'b1;
            cnt_q            <= cnt_d;
            if (cnt_d == CNT_FULL) begin
              state_q <= S_READY;
              full_q  <= 1'b1;
            end
          end
        end

        S_READY: begin
          if (start) begin
            i_q     <= '0;
            j_q     <= '0;
            state_q <= S_FETCH;
          end
        end

        S_FETCH: begin
          value_q <= mem[rd_addr];
          stb_q   <= 1'b1;
          state_q <= S_PRESENT;
        end

        S_PRESENT: begin
          if (value_ack) begin
            stb_q <= 1'b0;
            if (j_q == LAST) begin
              if (i_q == LAST) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                i_q     <= i_q + 5'd1;
                j_q     <= '0;
                state_q <= S_FETCH;
              end
            end else begin
              j_q     <= j_q + 5'd1;
              state_q <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          if (!start) begin
            valid_q <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= S_FILL;
          end
        end

        default: state_q <= S_FILL;
      endcase
    end
  end

  assign full      = full_q;
  assign value     = value_q;
  assign value_stb = stb_q;
  assign i         = i_q;
  assign j         = j_q;
  assign done      = done_q;

endmodule
